// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit owning HI/LO
// Purpose: one multiplier bit or quotient bit per cycle; 33-cycle latency per op.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start, op[1:0]       request strobe (IDLE only); 00 MULT 01 MULTU 10 DIV 11 DIVU
//   a[31:0], b[31:0]     operands, sampled with start
//   hi_we, lo_we, wdata  MTHI/MTLO writes, honoured only in IDLE
//   busy                 operation in flight
//   done                 one-cycle pulse when hi/lo carry a new result
//   div_by_zero          valid with done: divide had b == 0
//   hi[31:0], lo[31:0]   HI/LO registers
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_is_div;
  logic        r_sign_q;   // sign of product / quotient
  logic        r_sign_r;   // sign of remainder (dividend's sign)
  logic        r_b_zero;
  logic [31:0] r_a_raw;    // original dividend for the divide-by-zero result
  logic [31:0] r_opnd;     // multiplicand (mult) or divisor (div), magnitude form
  logic [63:0] r_acc;      // mult: {partial product, remaining multiplier}; div: {remainder, dividend/quotient}
  logic [4:0]  r_cnt;
  logic        r_done;
  logic        r_dbz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Operand magnitudes; MULT/DIV (op[0]==0) are signed. Negating 0x80000000
  // gives 0x80000000 which is correct when read as unsigned.
  logic        w_signed;
  logic [31:0] w_ua;
  logic [31:0] w_ub;
  assign w_signed = ~op[0];
  assign w_ua     = (w_signed && a[31]) ? (32'd0 - a) : a;
  assign w_ub     = (w_signed && b[31]) ? (32'd0 - b) : b;

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Restoring division step: shift the next dividend bit into the partial
  // remainder and keep the trial difference only if it did not go negative.
  logic [32:0] w_div_shift;
  logic [32:0] w_div_trial;
  logic        w_div_ge;
  logic [63:0] w_div_next;
  assign w_div_shift = {r_acc[63:32], r_acc[31]};
  assign w_div_trial = w_div_shift - {1'b0, r_opnd};
  assign w_div_ge    = ~w_div_trial[32];
  assign w_div_next  = {(w_div_ge ? w_div_trial[31:0] : w_div_shift[31:0]),
                        r_acc[30:0], w_div_ge};

  // Sign correction applied in FIXUP.
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  assign w_prod = r_sign_q ? (64'd0 - r_acc) : r_acc;
  assign w_quo  = r_sign_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_rem  = r_sign_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_is_div <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_b_zero <= 1'b0;
      r_a_raw  <= 32'd0;
      r_opnd   <= 32'd0;
      r_acc    <= 64'd0;
      r_cnt    <= 5'd0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_is_div <= op[1];
            r_sign_q <= w_signed & (a[31] ^ b[31]);
            r_sign_r <= w_signed & a[31];
            r_b_zero <= (b == 32'd0);
            r_a_raw  <= a;
            r_opnd   <= op[1] ? w_ub : w_ua;
            r_acc    <= {32'd0, (op[1] ? w_ua : w_ub)};
            r_cnt    <= 5'd0;
            r_dbz    <= 1'b0;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= FIXUP;
        end
        FIXUP: begin
          if (!r_is_div) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end else if (r_b_zero) begin
            r_hi <= r_a_raw;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_dbz   <= r_is_div & r_b_zero;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - table-driven self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[12];
  int   n_cmp;
  int   n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait for done; reports cycles from the accepting edge
  // to done, and whether busy stayed high across the whole calculation.
  task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                        output int lat, output bit busy_ok);
    bit found;
    start = 1'b1; op = o; a = va; b = vb;
    tick();
    start = 1'b0;
    busy_ok = (busy === 1'b1);
    lat = 0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      lat++;
      if (done === 1'b1) found = 1'b1;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  int          lat;
  bit          bok;
  int          n_done;
  logic [31:0] prev_hi;

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[5]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[6]  = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[8]  = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{2'b01, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 32'hA3D7_0A38, 1'b0};
    vecs[10] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0};

    tick();
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dbz",  {31'd0, div_by_zero}, 32'd0);
    chk("reset_hi",   hi, 32'd0);
    chk("reset_lo",   lo, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bok);
      chk($sformatf("v%0d_latency", i), lat, 32'd33);
      chk($sformatf("v%0d_busy", i), {31'd0, bok}, 32'd1);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      chk($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].exp_dbz});
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      tick();
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Second start during a MULT and an MTHI while busy: both ignored.
    prev_hi = hi;
    start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFD; b = 32'h0000_0007;
    tick();
    start = 1'b0;
    n_done = 0;
    lat = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5) begin start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4; end
      if (k == 7) begin hi_we = 1'b1; wdata = 32'h1234_5678; end
      tick();
      start = 1'b0; hi_we = 1'b0;
      if (k == 8) chk("busy_mthi_hi", hi, prev_hi);
      if (done === 1'b1) begin
        n_done++;
        lat = k;
        chk("ignored_start_hi", hi, 32'hFFFF_FFFF);
        chk("ignored_start_lo", lo, 32'hFFFF_FFEB);
      end
    end
    chk("ignored_start_ndone", n_done, 32'd1);
    chk("ignored_start_latency", lat, 32'd33);

    // Reset mid-operation: abort, clear HI/LO, no done.
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    chk("abort_ndone", n_done, 32'd0);

    // MTLO in IDLE.
    lo_we = 1'b1; wdata = 32'hCAFE_BABE;
    tick();
    lo_we = 1'b0;
    chk("idle_mtlo_lo", lo, 32'hCAFE_BABE);
    chk("idle_mtlo_hi", hi, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multi-cycle multiply/divide unit that owns the MIPS HI/LO register pair and serves the datapath's MULT, MULTU, DIV and DIVU requests over a start/busy/done handshake. It takes 64-bit products and quotient/remainder pairs off the single-cycle ALU path. The datapath raises a request and stalls on `busy`. The unit returns its results on `hi`/`lo`, which the datapath reads for MFHI/MFLO and writes for MTHI/MTLO.

## Interface
- No parameters; data width fixed at 32, iteration count fixed at 32.
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request strobe; sampled only in IDLE.
- `op` in 2: operation. 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a` in 32: multiplicand or dividend; sampled with `start`.
- `b` in 32: multiplier or divisor; sampled with `start`.
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in 32: MTHI/MTLO data.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse when `hi`/`lo` hold a new result.
- `div_by_zero` out 1: valid with `done`; high when a DIV/DIVU had `b == 0`.
- `hi` out 32: HI register (product upper word or remainder).
- `lo` out 32: LO register (product lower word or quotient).

## Operation
- States and transitions:
  - IDLE -> CALC on `start`.
  - CALC -> FIXUP after the 32nd iteration.
  - FIXUP -> IDLE, always.
- `busy` = (state != IDLE).
- Load (IDLE & `start`):
  - Latch `op`.
  - Latch `|a|` and `|b|` for signed ops, or raw `a` and `b` for unsigned ops. `|0x80000000|` = 0x80000000, treated as unsigned.
  - Latch the result sign: `a[31]^b[31]` for the quotient/product, `a[31]` for the remainder.
  - Clear the iteration counter.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle. 33-bit trial subtract of the divisor from the shifted partial remainder.
- FIXUP, multiply: negate the 64-bit product if signed and signs differ. Write HI = [63:32], LO = [31:0].
- FIXUP, divide:
  - Quotient truncates toward zero and is negated if signed and signs differ.
  - Remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
  - DIV 0x80000000 / 0xFFFFFFFF yields LO = 0x80000000, HI = 0. No flag is raised.
- Divide by zero:
  - Takes the full latency.
  - FIXUP forces LO = 0xFFFFFFFF and HI = `a` (original, unsigned form) for both DIV and DIVU.
  - `div_by_zero` = 1 with `done`.
- FIXUP asserts `done` for exactly one cycle. `div_by_zero` is cleared on every load.
- MTHI/MTLO:
  - `hi_we`/`lo_we` take effect at the next edge only when state == IDLE; ignored while busy.
  - If a write and `start` coincide, both take effect; the later result overwrites HI/LO.
- `start` while busy is ignored. No queueing, and the in-flight operation is unaffected.
- `hi`/`lo` hold their last value throughout CALC.

## Timing
- Reset values: state IDLE; `busy`, `done`, `div_by_zero` = 0; `hi`, `lo` = 0; counter 0.
- Start accepted at edge E0. `busy` is high from after E0. CALC occupies edges E1..E32. FIXUP occurs at edge E33.
- After E33: `hi`/`lo` hold the result, `done` = 1 for one cycle, `busy` = 0. Latency start-to-done is 33 cycles for every op.
- A new `start` is accepted in the `done` cycle (back-to-back throughput is 34 cycles per op).
- Reset mid-operation:
  - Aborts at the next edge and returns to reset values, including `hi`/`lo`.
  - No `done` is produced for the dropped op.
- `reset` has priority over `start`, `hi_we` and `lo_we`.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 -> `done` 33 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB; `busy` high for cycles 1..33.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MULT a=b=0x80000000 -> HI=0x40000000, LO=0.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 -> LO=3, HI=1. DIV a=7, b=-2 -> LO=0xFFFFFFFD, HI=1.
- DIV a=5, b=0 -> LO=0xFFFFFFFF, HI=5, `div_by_zero`=1 with `done`. Then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, `div_by_zero`=0.
- Second `start` at cycle 5 of a MULT -> ignored, single `done` with the first result. Then start MULTU 3*4 and assert `reset` at cycle 10 -> next cycle `busy`=0, `hi`=`lo`=0, no `done` pulse.
- `hi_we` with `wdata`=0x12345678 while busy -> HI unchanged. `lo_we` with 0xCAFEBABE in IDLE -> LO=0xCAFEBABE next cycle.
